max_pool_2x2: RTL and testbench
===============================

Name: max_pool_2x2

Overview:
- Downstream neighbour of the bias/ReLU/BN post-process stage. Consumes its post_out/post_out_valid stream: POX signed 16-bit pixels per beat, raster order, one output row at a time.
- Performs 2x2 stride-2 max pooling and emits POX/2 pooled pixels per beat on every odd row.
- Holds a one-row line buffer of horizontal maxima.
- No backpressure, matching the upstream stage.

Parameters:
- POX, 4, pixels per input beat; must be even (POX/2 pooled lanes).
- MAX_BEATS, 64, line-buffer depth (maximum beats per input row).
- BEAT_W, 6, width of the beat index; equals clog2(MAX_BEATS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame
- cfg_row_beats  in  16  beats per input row (row width / POX)
- cfg_rows  in  16  input rows in the frame
- in_data  in  POX*16  pixels, signed Q-format; lane p is bits [(p+1)*16-1:p*16]
- in_valid  in  1  in_data valid this cycle
- pool_out  out  (POX/2)*16  pooled pixels; lane q = max of input lanes 2q and 2q+1 over two rows
- pool_out_valid  out  1  pool_out valid (one cycle)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pooled beat

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; pool_out=0, pool_out_valid=0, busy=0, done=0; counters cleared. Line-buffer contents are don't-care.
- Reset mid-frame aborts the frame immediately. There is no done pulse and no further outputs.
- All comparisons are signed 16-bit. Outputs are exact input values; no saturation or rounding.
- FSM states: IDLE, EVEN_ROW, ODD_ROW, FINISH.
- IDLE, on start:
  - Latch beats = min(cfg_row_beats, MAX_BEATS) and rows = cfg_rows & ~1. An odd last row is dropped (floor).
  - If beats==0 or rows==0, go to FINISH.
  - Otherwise go to EVEN_ROW with beat_cnt=0, row_cnt=0.
  - in_valid in IDLE is ignored.
- EVEN_ROW:
  - Each in_valid beat writes linebuf[beat_cnt][q] = max(in[2q], in[2q+1]).
  - beat_cnt increments. At beats-1 it wraps to 0, row_cnt increments, and the state goes to ODD_ROW.
- ODD_ROW:
  - Each in_valid beat computes hmax[q] = max(in[2q], in[2q+1]).
  - On the next clk: pool_out[q] = max(hmax[q], linebuf[beat_cnt][q]) and pool_out_valid=1.
  - Latency is 1 cycle from the accepted odd-row beat.
  - At beat wrap, row_cnt increments. If row_cnt+1==rows go to FINISH, else go to EVEN_ROW.
- FINISH: done=1 for exactly one cycle, aligned with the cycle after the last pool_out_valid, or the cycle after start for an empty frame. Then go to IDLE.
- busy=1 in EVEN_ROW, ODD_ROW and FINISH.
- start while busy is ignored; the cfg latches are unchanged.
- Gaps in in_valid are permitted anywhere; counters advance only on in_valid.
- The line buffer is read combinationally at beat_cnt. The same-address write then read always spans different rows, so there is no bypass hazard.
- pool_out holds its last value when pool_out_valid=0.

Decomposition:
- Shared package holds:
  - PIX_W=16.
  - FSM state typedef {IDLE, EVEN_ROW, ODD_ROW, FINISH}.
  - A signed max16 function, also reusable by other pooling variants.
- One sub-module: pool_line_buf, a register array of MAX_BEATS x (POX/2)*16 with synchronous write and combinational read.

Test Plan:
- POX=4, beats=1, rows=2. Row0 [1,5,-3,2], row1 [4,0,-7,-1] -> one output one cycle after row1: lane0=5, lane1=2. done one cycle later.
- beats=3, rows=4, ramp pixels (value = row*100 + col), in_valid random 50% -> 6 outputs in raster order, each equal to the bottom-right pixel of its window. Exactly one done.
- rows=3 -> the third row is consumed and ignored; 1 output row only; done follows the last row1 output.
- start with cfg_row_beats=0 -> done on the next cycle, no pool_out_valid, busy high for 1 cycle. A second start while busy is ignored.
- All pixels 0x8000 except one 0x7FFF per window -> every output is 0x7FFF (signed compare). cfg_row_beats=200 clamps to 64.
- rst low during ODD_ROW -> next cycle all outputs 0 and state IDLE. A fresh start then runs a full correct frame.

Source files
------------

// File: rtl/max_pool_2x2_pkg.sv
// Shared types and helpers for the 2x2 max-pooling stage and its variants.
package max_pool_2x2_pkg;

  localparam int PIX_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2,
    FINISH   = 2'd3
  } state_t;

  function automatic logic signed [PIX_W-1:0] max16(input logic signed [PIX_W-1:0] a,
                                                    input logic signed [PIX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_2x2_line_buf.sv
// One-row buffer of horizontal maxima: synchronous write, combinational read.
module pool_line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster stream of POX pixels per beat;
// even rows fill the line buffer, odd rows combine with it and emit POX/2 lanes.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int POX       = 4,
  parameter int MAX_BEATS = 64,
  parameter int BEAT_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 cfg_row_beats,
  input  logic [15:0]                 cfg_rows,
  input  logic [POX*PIX_W-1:0]        in_data,
  input  logic                        in_valid,
  output logic [(POX/2)*PIX_W-1:0]    pool_out,
  output logic                        pool_out_valid,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  state_dbg
);

  localparam int LANES = POX / 2;
  localparam int OW    = LANES * PIX_W;
  localparam logic [BEAT_W:0] MAX_BEATS_W = (BEAT_W + 1)'(MAX_BEATS);

  state_t              state;
  logic [BEAT_W:0]     beats_q;
  logic [15:0]         rows_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [15:0]         row_cnt;

  logic [OW-1:0]       hmax;
  logic [OW-1:0]       pooled;
  logic [OW-1:0]       lb_rdata;
  logic [BEAT_W:0]     beats_clamp;
  logic [15:0]         rows_even;
  logic                last_beat;

  // Horizontal max of each lane pair, then vertical max against the stored row.
  always_comb begin
    hmax   = '0;
    pooled = '0;
    for (int q = 0; q < LANES; q++) begin
      hmax[q*PIX_W +: PIX_W]   = max16(in_data[(2*q)*PIX_W +: PIX_W],
                                       in_data[(2*q+1)*PIX_W +: PIX_W]);
      pooled[q*PIX_W +: PIX_W] = max16(hmax[q*PIX_W +: PIX_W],
                                       lb_rdata[q*PIX_W +: PIX_W]);
    end
  end

  assign beats_clamp = (cfg_row_beats > 16'(MAX_BEATS)) ? MAX_BEATS_W
                                                         : cfg_row_beats[BEAT_W:0];
  assign rows_even   = cfg_rows & 16'hFFFE;
  assign last_beat   = ({1'b0, beat_cnt} == (beats_q - (BEAT_W + 1)'(1)));
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  pool_line_buf #(
    .DEPTH (MAX_BEATS),
    .AW    (BEAT_W),
    .W     (OW)
  ) u_line_buf (
    .clk   (clk),
    .we    ((state == EVEN_ROW) && in_valid),
    .waddr (beat_cnt),
    .wdata (hmax),
    .raddr (beat_cnt),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      beats_q        <= '0;
      rows_q         <= '0;
      beat_cnt       <= '0;
      row_cnt        <= '0;
      pool_out       <= '0;
      pool_out_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      pool_out_valid <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            beats_q  <= beats_clamp;
            rows_q   <= rows_even;
            beat_cnt <= '0;
            row_cnt  <= '0;
            // An empty frame pulses done right away; FINISH then stays quiet.
            if ((beats_clamp == '0) || (rows_even == '0)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= EVEN_ROW;
            end
          end
        end
        EVEN_ROW: begin
          if (in_valid) begin
            if (last_beat) begin
              beat_cnt <= '0;
              row_cnt  <= row_cnt + 16'd1;
              state    <= ODD_ROW;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ODD_ROW: begin
          if (in_valid) begin
            pool_out       <= pooled;
            pool_out_valid <= 1'b1;
            if (last_beat) begin
              beat_cnt <= '0;
              row_cnt  <= row_cnt + 16'd1;
              state    <= ((row_cnt + 16'd1) == rows_q) ? FINISH : EVEN_ROW;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        FINISH: begin
          done  <= (beats_q != '0) && (rows_q != '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: window-max reference model plus directed steps.
module tb_max_pool_2x2;
  import max_pool_2x2_pkg::*;

  localparam int POX = 4;
  localparam int IW  = POX * 16;
  localparam int OW  = (POX / 2) * 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [15:0]   cfg_row_beats = '0;
  logic [15:0]   cfg_rows = '0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [OW-1:0] pool_out;
  logic          pool_out_valid;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  max_pool_2x2 #(.POX(POX), .MAX_BEATS(64), .BEAT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_row_beats  (cfg_row_beats),
    .cfg_rows       (cfg_rows),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .pool_out       (pool_out),
    .pool_out_valid (pool_out_valid),
    .busy           (busy),
    .done           (done),
    .state_dbg      (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_done  = 0;
  logic [OW-1:0] exp_q[$];
  logic signed [15:0] pix [0:3][0:255];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every valid beat must match the head of the expected queue
  always @(negedge clk) begin
    if (pool_out_valid) begin
      n_valid++;
      check("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("pool_out", 64'(pool_out), 64'(exp_q.pop_front()));
    end
    if (done) n_done++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int beats, input int rows);
    start = 1'b1;
    cfg_row_beats = 16'(beats);
    cfg_rows = 16'(rows);
    tick();
    start = 1'b0;
  endtask

  // mode 1: ramp, 2: random, 3: 0x8000 with one 0x7FFF per window, else preset
  task automatic fill(input int mode, input int rows, input int cols);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        case (mode)
          1: pix[r][c] = 16'(r * 100 + c);
          2: pix[r][c] = 16'($urandom);
          3: pix[r][c] = 16'h8000;
          default: ;
        endcase
    if (mode == 3)
      for (int r = 0; r + 1 < rows; r += 2)
        for (int c = 0; c < cols; c += 2) begin
          int k = $urandom_range(0, 3);
          pix[r + k / 2][c + k % 2] = 16'h7FFF;
        end
  endtask

  // reference: each output lane is the max of its 2x2 window
  task automatic build_expected(input int rows_eff, input int beats);
    for (int r = 0; r < rows_eff; r += 2)
      for (int b = 0; b < beats; b++) begin
        logic [OW-1:0] word;
        word = '0;
        for (int q = 0; q < POX / 2; q++) begin
          logic signed [15:0] m;
          m = pix[r][b * POX + 2 * q];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (pix[r + dr][b * POX + 2 * q + dc] > m) m = pix[r + dr][b * POX + 2 * q + dc];
          word[q * 16 +: 16] = m;
        end
        exp_q.push_back(word);
      end
  endtask

  task automatic send_beat(input int r, input int b);
    for (int p = 0; p < POX; p++) in_data[p * 16 +: 16] = pix[r][b * POX + p];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int beats_cfg, input int rows_cfg, input int mode, input bit gappy);
    int beats, rows_eff, v0, d0;
    beats = (beats_cfg > 64) ? 64 : beats_cfg;
    rows_eff = rows_cfg & ~1;
    fill(mode, rows_cfg, beats * POX);
    build_expected(rows_eff, beats);
    v0 = n_valid;
    d0 = n_done;
    do_start(beats_cfg, rows_cfg);
    check("busy_after_start", 64'(busy), 64'd1);
    for (int r = 0; r < rows_cfg; r++)
      for (int b = 0; b < beats; b++) begin
        if (gappy) repeat ($urandom_range(0, 1)) tick();
        send_beat(r, b);
        if ((r % 2 == 1) && (r < rows_eff)) begin
          @(negedge clk);
          check("latency_valid", 64'(pool_out_valid), 64'd1);
          if ((r == rows_eff - 1) && (b == beats - 1)) begin
            @(negedge clk);
            check("done_after_last", 64'(done), 64'd1);
          end
        end
      end
    repeat (4) tick();
    check("frame_valid_count", 64'(n_valid - v0), 64'((rows_eff / 2) * beats));
    check("frame_done_count", 64'(n_done - d0), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int d0, v0;
    // reset state
    repeat (3) tick();
    check("rst_pool_out", 64'(pool_out), 64'd0);
    check("rst_valid", 64'(pool_out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    rst = 1'b1;
    tick();

    // directed single window
    pix[0][0] = 16'sd1; pix[0][1] = 16'sd5; pix[0][2] = -16'sd3; pix[0][3] = 16'sd2;
    pix[1][0] = 16'sd4; pix[1][1] = 16'sd0; pix[1][2] = -16'sd7; pix[1][3] = -16'sd1;
    run_frame(1, 2, 0, 1'b0);
    check("t1_hold", 64'(pool_out), 64'h0002_0005);

    // ramp with gappy in_valid, then odd row count
    run_frame(3, 4, 1, 1'b1);
    run_frame(2, 3, 1, 1'b1);
    run_frame(5, 4, 2, 1'b1);

    // empty frame plus ignored start while busy
    d0 = n_done;
    v0 = n_valid;
    do_start(0, 4);
    check("empty_busy", 64'(busy), 64'd1);
    check("empty_done", 64'(done), 64'd1);
    do_start(3, 2);
    check("empty_busy_after", 64'(busy), 64'd0);
    check("empty_done_after", 64'(done), 64'd0);
    check("ignored_start_state", 64'(state_dbg), 64'(IDLE));
    repeat (5) tick();
    check("empty_done_count", 64'(n_done - d0), 64'd1);
    check("empty_no_valid", 64'(n_valid - v0), 64'd0);

    // signed compare with clamped row width
    run_frame(200, 2, 3, 1'b0);
    check("signed_hold", 64'(pool_out), 64'h7FFF_7FFF);

    // reset in the middle of an odd row
    fill(2, 2, 2 * POX);
    d0 = n_done;
    do_start(2, 2);
    send_beat(0, 0);
    send_beat(0, 1);
    check("pre_rst_state", 64'(state_dbg), 64'(ODD_ROW));
    rst = 1'b0;
    tick();
    check("mid_rst_pool_out", 64'(pool_out), 64'd0);
    check("mid_rst_valid", 64'(pool_out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    rst = 1'b1;
    repeat (3) tick();
    check("mid_rst_no_done", 64'(n_done - d0), 64'd0);
    run_frame(4, 4, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
